// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character LCD sequencer.
// The top-level FSM states, the four-phase byte-write enum and the
// command bytes live here so the top and the byte writer agree on them.
package lcd_pkg;

  // Top-level sequencing states.
  typedef enum logic [1:0] {
    ST_PWR_WAIT = 2'd0,
    ST_INIT     = 2'd1,
    ST_IDLE     = 2'd2,
    ST_UPDATE   = 2'd3
  } top_state_e;

  // Phases of a single byte transfer on the LCD bus.
  typedef enum logic [1:0] {
    PH_LOAD   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_STROBE = 2'd2,
    PH_HOLD   = 2'd3
  } byte_phase_e;

  // HD44780 command bytes used by the sequencer.
  localparam logic [7:0] LCD_FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;  // display on, cursor off, no blink
  localparam logic [7:0] LCD_ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] LCD_CLEAR    = 8'h01;  // clear display, home cursor
  localparam logic [7:0] LCD_LINE1    = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] LCD_LINE2    = 8'hC0;  // DDRAM address 0x40
  localparam logic [7:0] LCD_SPACE    = 8'h20;  // ASCII space

  // Number of commands in the init list.
  localparam int INIT_LEN = 4;

  // Init command list, indexed by position in the list.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    case (idx)
      2'd0:    cmd = LCD_FUNC_SET;
      2'd1:    cmd = LCD_DISP_ON;
      2'd2:    cmd = LCD_ENTRY;
      default: cmd = LCD_CLEAR;
    endcase
    return cmd;
  endfunction

  // Null characters become spaces so a null-terminated string blanks
  // the remainder of its line instead of printing CGRAM glyph 0.
  function automatic logic [7:0] blank_null(input logic [7:0] c);
    return (c == 8'h00) ? LCD_SPACE : c;
  endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// Four-phase LCD bus writer: LOAD, SETUP, STROBE, HOLD.
//
// Handshake: start_i is level-sensitive. A cycle in which the writer is in
// LOAD with start_i high is the LOAD cycle of a byte; rs_in_i/data_in_i are
// captured on the edge that ends it. done_o is high during HOLD, so the
// requester may present the next byte with start_i high in the very next
// cycle and bytes run back to back with no gap.
module lcd_byte_writer
  import lcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       rs_in_i,
  input  logic [7:0] data_in_i,
  output logic       done_o,
  output byte_phase_e phase_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic [7:0] lcd_data_o
);

  byte_phase_e phase_q;
  logic        lcd_e_q;
  logic        lcd_rs_q;
  logic [7:0]  lcd_data_q;

  // Phase counter and registered bus outputs; E is high only in STROBE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q    <= PH_LOAD;
      lcd_e_q    <= 1'b0;
      lcd_rs_q   <= 1'b0;
      lcd_data_q <= 8'h00;
    end else begin
      case (phase_q)
        PH_LOAD: begin
          if (start_i) begin
            lcd_rs_q   <= rs_in_i;
            lcd_data_q <= data_in_i;
            phase_q    <= PH_SETUP;
          end
        end
        PH_SETUP: begin
          lcd_e_q <= 1'b1;
          phase_q <= PH_STROBE;
        end
        PH_STROBE: begin
          lcd_e_q <= 1'b0;
          phase_q <= PH_HOLD;
        end
        default: begin
          phase_q <= PH_LOAD;
        end
      endcase
    end
  end

  assign done_o     = (phase_q == PH_HOLD);
  assign phase_o    = phase_q;
  assign lcd_e_o    = lcd_e_q;
  assign lcd_rs_o   = lcd_rs_q;
  assign lcd_data_o = lcd_data_q;

endmodule

// File: rtl/lcd_seq_ctrl.sv
// Character LCD sequencer: power-up wait, init command list, then full
// two-line refreshes from an external character buffer on request.
// The byte writer owns the LCD pins; this module owns the top FSM, the
// byte index within the current list and the buffer read address.
module lcd_seq_ctrl
  import lcd_pkg::*;
#(
  parameter int CHARS_PER_LINE = 16,
  parameter int POWERUP_CYC    = 4,
  parameter int AW             = 5
) (
  input  logic          clk_100hz,
  input  logic          rst,
  input  logic          upd_req,
  output logic          upd_ack,
  output logic          busy,
  output logic [AW-1:0] char_addr,
  input  logic [7:0]    char_data,
  output logic          lcd_e,
  output logic          lcd_rs,
  output logic          lcd_rw,
  output logic [7:0]    lcd_data
);

  localparam int N      = CHARS_PER_LINE;
  // Refresh list: LINE1 cmd, N chars, LINE2 cmd, N chars.
  localparam int NBYTES = 2 * N + 2;
  localparam int IW     = $clog2(NBYTES + 1);
  localparam int CW     = (POWERUP_CYC > 1) ? $clog2(POWERUP_CYC) : 1;

  localparam logic [IW-1:0] LAST_UPD  = IW'(NBYTES - 1);
  localparam logic [IW-1:0] LAST_INIT = IW'(INIT_LEN - 1);
  localparam logic [IW-1:0] LINE2_IDX = IW'(N + 1);
  localparam logic [CW-1:0] PWR_LAST  = CW'(POWERUP_CYC - 1);

  top_state_e    state_q;
  logic [CW-1:0] pwr_cnt_q;
  logic [IW-1:0] idx_q;
  logic [AW-1:0] char_addr_q;
  logic          busy_q;
  logic          upd_ack_q;

  logic [IW-1:0] idx_nxt;
  logic          wr_start;
  logic          wr_rs;
  logic [7:0]    wr_data;
  logic          wr_done;
  byte_phase_e   wr_phase;

  // A refresh-list position carries a character unless it is one of the
  // two DDRAM address commands.
  function automatic logic is_data(input logic [IW-1:0] i);
    return (i != '0) && (i != LINE2_IDX);
  endfunction

  // Buffer address for a character position in the refresh list:
  // positions 1..N map to 0..N-1, positions N+2..2N+1 map to N..2N-1.
  function automatic logic [AW-1:0] addr_of(input logic [IW-1:0] i);
    return (i > LINE2_IDX) ? AW'(i - IW'(2)) : AW'(i - IW'(1));
  endfunction

  assign idx_nxt  = idx_q + IW'(1);
  assign wr_start = (state_q == ST_INIT) || (state_q == ST_UPDATE);

  // Byte presented to the writer: init command, address command or
  // buffer character. The writer only samples it in its LOAD cycle.
  always_comb begin
    wr_rs   = 1'b0;
    wr_data = 8'h00;
    case (state_q)
      ST_INIT: begin
        wr_data = init_cmd(idx_q[1:0]);
      end
      ST_UPDATE: begin
        if (idx_q == '0) begin
          wr_data = LCD_LINE1;
        end else if (idx_q == LINE2_IDX) begin
          wr_data = LCD_LINE2;
        end else begin
          wr_rs   = 1'b1;
          wr_data = blank_null(char_data);
        end
      end
      default: ;
    endcase
  end

  // Top FSM: power-up wait, init list, idle, refresh. The buffer address
  // for a character is loaded on the edge that starts its LOAD cycle and
  // held otherwise, so char_data is stable when the writer samples it.
  always_ff @(posedge clk_100hz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_PWR_WAIT;
      pwr_cnt_q   <= '0;
      idx_q       <= '0;
      char_addr_q <= '0;
      busy_q      <= 1'b1;
      upd_ack_q   <= 1'b0;
    end else begin
      upd_ack_q <= 1'b0;
      case (state_q)
        ST_PWR_WAIT: begin
          if (pwr_cnt_q == PWR_LAST) begin
            pwr_cnt_q <= '0;
            idx_q     <= '0;
            state_q   <= ST_INIT;
          end else begin
            pwr_cnt_q <= pwr_cnt_q + CW'(1);
          end
        end
        ST_INIT: begin
          if (wr_done) begin
            if (idx_q == LAST_INIT) begin
              idx_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q <= idx_nxt;
            end
          end
        end
        ST_IDLE: begin
          if (upd_req) begin
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_UPDATE;
          end
        end
        default: begin
          if (wr_done) begin
            if (idx_q == LAST_UPD) begin
              idx_q     <= '0;
              busy_q    <= 1'b0;
              upd_ack_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else begin
              idx_q <= idx_nxt;
              if (is_data(idx_nxt)) begin
                char_addr_q <= addr_of(idx_nxt);
              end
            end
          end
        end
      endcase
    end
  end

  lcd_byte_writer u_writer (
    .clk_i      (clk_100hz),
    .rst_i      (rst),
    .start_i    (wr_start),
    .rs_in_i    (wr_rs),
    .data_in_i  (wr_data),
    .done_o     (wr_done),
    .phase_o    (wr_phase),
    .lcd_e_o    (lcd_e),
    .lcd_rs_o   (lcd_rs),
    .lcd_data_o (lcd_data)
  );

  // The writer always starts in LOAD whenever the top FSM hands it a byte;
  // the phase is kept visible here for checkers bound to this module.
  byte_phase_e dbg_phase;
  assign dbg_phase = wr_phase;

  assign upd_ack   = upd_ack_q;
  assign busy      = busy_q;
  assign char_addr = char_addr_q;
  assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed-sequence bench for lcd_seq_ctrl with randomized character
// buffers. A monitor records every E strobe (rs, data, cycle and the
// char_addr seen in that byte's LOAD cycle) and every ack; the expected
// byte stream is built from the buffer contents by a list model.
`timescale 1ns/1ps
module tb_lcd_seq_ctrl;

  localparam int N  = 16;
  localparam int AW = 5;

  // ---------------- clock / reset / DUT ----------------
  logic          clk_100hz = 1'b0;
  logic          rst;
  logic          upd_req;
  logic          upd_ack;
  logic          busy;
  logic [AW-1:0] char_addr;
  logic [7:0]    char_data;
  logic          lcd_e;
  logic          lcd_rs;
  logic          lcd_rw;
  logic [7:0]    lcd_data;

  logic [7:0] buf_mem [0:2*N-1];
  assign char_data = buf_mem[char_addr];

  always #5 clk_100hz = ~clk_100hz;

  lcd_seq_ctrl #(.CHARS_PER_LINE(N), .POWERUP_CYC(4), .AW(AW)) dut (
    .clk_100hz (clk_100hz),
    .rst       (rst),
    .upd_req   (upd_req),
    .upd_ack   (upd_ack),
    .busy      (busy),
    .char_addr (char_addr),
    .char_data (char_data),
    .lcd_e     (lcd_e),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_data  (lcd_data)
  );

  // ---------------- monitor ----------------
  logic [8:0]    str_q[$];
  int            str_cyc_q[$];
  int            str_addr_q[$];
  int            ack_cyc_q[$];
  int            cyc = 0;
  int            first_idle = 0;
  int            idle_cnt = 0;
  int            e_twice = 0;
  int            rw_bad = 0;
  logic          e_prev = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic [AW-1:0] a2 = '0;

  always @(negedge clk_100hz) begin
    if (rst) begin
      cyc        = 0;
      first_idle = 0;
      idle_cnt   = 0;
      e_prev     = 1'b0;
      a1         = '0;
      a2         = '0;
    end else begin
      cyc = cyc + 1;
      if (lcd_e === 1'b1) begin
        str_q.push_back({lcd_rs, lcd_data});
        str_cyc_q.push_back(cyc);
        str_addr_q.push_back(int'(a2));
      end
      if (lcd_e === 1'b1 && e_prev === 1'b1) e_twice = e_twice + 1;
      if (lcd_rw !== 1'b0) rw_bad = rw_bad + 1;
      if (upd_ack === 1'b1) ack_cyc_q.push_back(cyc);
      if (busy === 1'b0) begin
        idle_cnt = idle_cnt + 1;
        if (first_idle == 0) first_idle = cyc;
      end
      e_prev = lcd_e;
      a2     = a1;
      a1     = char_addr;
    end
  end

  // ---------------- scoreboard / model ----------------
  logic [8:0] exp_q[$];
  int         exp_addr_q[$];
  int         pass_cnt = 0;
  int         total_cnt = 0;

  // Expected refresh stream: line-1 address command, line-1 characters,
  // line-2 address command, line-2 characters; nulls shown as spaces.
  function automatic void build_model();
    exp_q.delete();
    exp_addr_q.delete();
    for (int line = 0; line < 2; line++) begin
      exp_q.push_back({1'b0, (line == 0) ? 8'h80 : 8'hC0});
      exp_addr_q.push_back(-1);
      for (int i = 0; i < N; i++) begin
        exp_q.push_back({1'b1, (buf_mem[line*N+i] == 8'h00) ? 8'h20 : buf_mem[line*N+i]});
        exp_addr_q.push_back(line * N + i);
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) begin
      pass_cnt = pass_cnt + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk_100hz);
    #1;
  endtask

  task automatic wait_cycle(input int target);
    for (int g = 0; g < 1000 && cyc < target; g++) tick();
    check("wait_cycle", (cyc >= target), 1);
  endtask

  task automatic clear_mon();
    str_q.delete();
    str_cyc_q.delete();
    str_addr_q.delete();
    ack_cyc_q.delete();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_e"},    lcd_e,     0);
    check({tag, "_rs"},   lcd_rs,    0);
    check({tag, "_rw"},   lcd_rw,    0);
    check({tag, "_data"}, lcd_data,  0);
    check({tag, "_addr"}, char_addr, 0);
    check({tag, "_ack"},  upd_ack,   0);
    check({tag, "_busy"}, busy,      1);
  endtask

  // Hold reset for two cycles, then release just after a rising edge so
  // the cycle containing the release is cycle 1.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    check_reset_vals(tag);
    clear_mon();
    @(posedge clk_100hz);
    #1;
    rst = 1'b0;
  endtask

  task automatic randomize_buf();
    for (int i = 0; i < 2*N; i++)
      buf_mem[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(33, 126));
  endtask

  task automatic load_line(input int line, input string s);
    for (int i = 0; i < N; i++)
      buf_mem[line*N+i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  // Power-up wait then four init commands at cycles 7, 11, 15, 19.
  task automatic check_init(input string tag);
    logic [7:0] cmds [0:3];
    cmds[0] = 8'h38; cmds[1] = 8'h0C; cmds[2] = 8'h06; cmds[3] = 8'h01;
    wait_cycle(23);
    check({tag, "_nstr"}, str_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_cmd%0d", tag, k),
            (k < str_q.size()) ? 32'(str_q[k]) : 32'hFFFF, {23'd0, 1'b0, cmds[k]});
      check($sformatf("%s_cyc%0d", tag, k),
            (k < str_cyc_q.size()) ? str_cyc_q[k] : -1, 7 + 4*k);
    end
    check({tag, "_busy_fall"}, first_idle, 21);
    check({tag, "_noack"}, ack_cyc_q.size(), 0);
  endtask

  // Compare a refresh accepted at the end of cycle c, starting at strobe
  // index base, against the model.
  task automatic check_refresh_at(input string tag, input int base, input int c);
    for (int k = 0; k < exp_q.size(); k++) begin
      int idx;
      idx = base + k;
      check($sformatf("%s_b%0d", tag, k),
            (idx < str_q.size()) ? 32'(str_q[idx]) : 32'hFFFF, 32'(exp_q[k]));
      check($sformatf("%s_c%0d", tag, k),
            (idx < str_cyc_q.size()) ? str_cyc_q[idx] : -1, c + 3 + 4*k);
      if (exp_addr_q[k] >= 0)
        check($sformatf("%s_a%0d", tag, k),
              (idx < str_addr_q.size()) ? str_addr_q[idx] : -1, exp_addr_q[k]);
    end
  endtask

  task automatic do_refresh(input string tag);
    int c;
    int got;
    check({tag, "_idle"}, busy, 0);
    clear_mon();
    build_model();
    upd_req = 1'b1;
    c = cyc;
    got = 0;
    for (int i = 0; i < 400 && got == 0; i++) begin
      tick();
      if (ack_cyc_q.size() > 0) begin
        got = 1;
        upd_req = 1'b0;
      end
    end
    upd_req = 1'b0;
    check({tag, "_ack_seen"}, got, 1);
    check({tag, "_ack_cyc"}, (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1, c + 137);
    check({tag, "_nstr"}, str_q.size(), 34);
    check_refresh_at(tag, 0, c);
    tick();
    tick();
    check({tag, "_one_ack"}, ack_cyc_q.size(), 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int got;
    rst     = 1'b1;
    upd_req = 1'b0;
    load_line(0, "mode 0");
    load_line(1, "watch");

    // Reset state and the init sequence with no request pending.
    #1;
    check_reset_vals("por");
    do_reset("rst0");
    check_init("init0");

    // Directed buffer, then two random buffers.
    do_refresh("mode0");
    randomize_buf();
    do_refresh("rand1");
    randomize_buf();
    do_refresh("rand2");

    // Request held from reset: not acknowledged during power-up or init,
    // accepted on the first idle edge, and two back-to-back refreshes with
    // exactly one idle/ack cycle between them.
    randomize_buf();
    build_model();
    upd_req = 1'b1;
    do_reset("rst1");
    check_init("init1");
    got = 0;
    for (int i = 0; i < 700 && got == 0; i++) begin
      tick();
      if (ack_cyc_q.size() >= 2) begin
        got = 1;
        upd_req = 1'b0;
      end
    end
    upd_req = 1'b0;
    check("held_two_acks", got, 1);
    check("held_ack0", (ack_cyc_q.size() > 0) ? ack_cyc_q[0] : -1, 158);
    check("held_ack1", (ack_cyc_q.size() > 1) ? ack_cyc_q[1] : -1, 295);
    check("held_idle_cycles", idle_cnt, 3);
    check("held_nstr", str_q.size(), 72);
    check_refresh_at("held1", 4, 21);
    check_refresh_at("held2", 38, 158);
    tick();
    tick();
    check("held_no_third", ack_cyc_q.size(), 2);

    // Reset in the middle of a refresh: immediate reset values, the init
    // sequence repeats and the aborted refresh is never acknowledged.
    randomize_buf();
    clear_mon();
    upd_req = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      tick();
      if (str_q.size() >= 11) got = 1;
    end
    upd_req = 1'b0;
    check("abort_reached", got, 1);
    check("abort_busy", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("abort_async");
    do_reset("abort_rst");
    check_init("init2");
    wait_cycle(170);
    check("abort_noack", ack_cyc_q.size(), 0);

    // Normal operation resumes after the abort.
    randomize_buf();
    do_refresh("rand3");

    check("no_double_e", e_twice, 0);
    check("rw_low", rw_bad, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
